uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Sits directly downstream of the RS232 receiver, replacing the echo loop in the top level.
//  Assembles framed command bytes into memory read/write requests for the computer's bus.
//  Returns an ACK/NAK byte or the read data through the RS232 transmitter.
//  Host frame formats:
//   'W' addr data : write
//   'R' addr      : read
//  Multi-byte fields are MSB first.
// PARAMETERS
//  ADDR_BYTES      2        address field bytes; mem_addr width = 8*ADDR_BYTES
//  DATA_BYTES      4        data field bytes; mem data width = 8*DATA_BYTES
//  TIMEOUT_CYCLES  500000   max clk cycles between bytes of one frame before abort
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-low
//  rx_byte      in   8      received byte (RS232 RX)
//  rx_valid     in   1      1-cycle strobe: rx_byte valid (RS232 hasRX)
//  tx_byte      out  8      byte to transmit (RS232 TX)
//  en_tx        out  1      1-cycle transmit strobe (RS232 en_TX)
//  tx_ready     in   1      transmitter idle (RS232 TX_ready)
//  mem_addr     out  8*AB   request address
//  mem_wdata    out  8*DB   write data
//  mem_we       out  1      1-cycle write strobe
//  mem_re       out  1      1-cycle read strobe
//  mem_rdata    in   8*DB   read data, valid with mem_rvalid
//  mem_rvalid   in   1      read data strobe, arbitrary latency >= 1 cycle
//  frame_err    out  1      sticky: bad opcode, timeout or RX overrun; cleared by reset only
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, counters 0.
//  Opcodes: 'W'=8'h57, 'R'=8'h52. Replies: ACK=8'h06, NAK=8'h15.
//  IDLE
//   - rx_valid with 'W' or 'R' -> ADDR, byte counter cleared.
//   - Any other byte -> queue NAK, set frame_err -> SEND.
//  ADDR
//   - Shift each byte in as the LSB of the address shift register.
//   - After ADDR_BYTES bytes: 'W' -> DATA; 'R' -> READ_REQ.
//  DATA
//   - Same shifting for DATA_BYTES bytes -> WRITE.
//  WRITE
//   - mem_we=1 for exactly 1 cycle with final mem_addr/mem_wdata.
//   - Queue ACK -> SEND.
//  READ_REQ
//   - mem_re=1 for exactly 1 cycle -> READ_WAIT.
//  READ_WAIT
//   - On mem_rvalid, capture mem_rdata; queue DATA_BYTES bytes MSB first -> SEND.
//   - No timeout in this state.
//  SEND
//   - Present the next byte on tx_byte and pulse en_tx only in a cycle where tx_ready=1.
//   - After each pulse, 1-cycle gap; tx_ready is ignored that cycle, so en_tx is never high on consecutive cycles.
//   - After the last byte -> IDLE.
//  Timeout
//   - In ADDR/DATA, a counter resets on every rx_valid and increments otherwise.
//   - At TIMEOUT_CYCLES: discard frame, set frame_err, no reply -> IDLE.
//  Overrun
//   - rx_valid in WRITE/READ_REQ/READ_WAIT/SEND: byte dropped, frame_err set, state unaffected.
//  Simultaneous rx_valid and timeout expiry: the byte wins and the counter clears.
//  Shift registers are plain, not saturating; reused frames fully overwrite the previous address/data.
//  Reset mid-frame or mid-send: immediate return to IDLE with outputs 0; a partial TX byte already in RS232 is its problem.
// STRUCTURE
//  Package uart_cmd_pkg:
//   - OP_WRITE, OP_READ, ACK, NAK constants.
//   - state_t enum {IDLE, ADDR, DATA, WRITE, READ_REQ, READ_WAIT, SEND}.
//  Sub-module uart_byte_timer:
//   - Inter-byte timeout counter; inputs clear and run, output expired.
//   - Parameter TIMEOUT_CYCLES.
//  FSM, shift registers and reply byte queue (DATA_BYTES entries, index counter) live here.
// TESTING (ADDR_BYTES=2, DATA_BYTES=4, TIMEOUT_CYCLES=100)
//  1. Write: RX 57 12 34 DE AD BE EF -> one mem_we, mem_addr=16'h1234, mem_wdata=32'hDEADBEEF; TX 06; frame_err=0.
//  2. Read: RX 52 12 34; model returns 32'hCAFEF00D 5 cycles after mem_re -> TX CA FE F0 0D in order, one en_tx per tx_ready window.
//  3. Bad opcode: RX 41 -> TX 15, frame_err=1, no mem strobe; a following valid write frame still completes.
//  4. Timeout: RX 57 12, then 150 idle cycles -> frame_err=1, no TX, no mem_we; a later RX 52 00 00 starts a fresh read.
//  5. Overrun: send RX 33 while tx_ready=0 holds SEND -> byte dropped, frame_err=1, original reply still sent intact.
//  6. Reset: assert rst low during DATA after 2 data bytes -> all outputs 0, busy=0; full frame after release works.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state type for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ_REQ,
    READ_WAIT,
    SEND
  } state_t;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter: counts idle cycles while run is high, flags expiry.
module uart_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !run) begin
      count_d = '0;
    end else if (count_q != CntW'(TIMEOUT_CYCLES)) begin
      count_d = count_q + CntW'(1);
    end
  end

  assign expired = run && (count_q == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Turns framed RS232 command bytes into memory read/write strobes and queues
// the ACK/NAK or read-data reply back to the transmitter.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_BYTES     = 2,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [7:0]              tx_byte,
  output logic                    en_tx,
  input  logic                    tx_ready,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int unsigned AW       = 8 * ADDR_BYTES;
  localparam int unsigned DW       = 8 * DATA_BYTES;
  localparam int unsigned MaxBytes = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned CntW     = $clog2(MaxBytes + 1);
  localparam int unsigned IdxW     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  state_t          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      txq_q [DATA_BYTES];
  logic [7:0]      txq_d [DATA_BYTES];
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] last_q, last_d;
  logic            gap_q, gap_d;
  logic            frame_err_q, frame_err_d;

  logic timer_run;
  logic timer_expired;

  assign timer_run = (state_q == ADDR) || (state_q == DATA);

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid),
    .run    (timer_run),
    .expired(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    txq_d       = txq_q;
    idx_d       = idx_q;
    last_d      = last_q;
    gap_d       = 1'b0;
    frame_err_d = frame_err_q;
    tx_byte     = 8'h00;
    en_tx       = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_byte == OP_WRITE) || (rx_byte == OP_READ)) begin
            is_write_d = (rx_byte == OP_WRITE);
            cnt_d      = '0;
            state_d    = ADDR;
          end else begin
            txq_d[0]    = NAK;
            idx_d       = '0;
            last_d      = '0;
            frame_err_d = 1'b1;
            state_d     = SEND;
          end
        end
      end

      // A byte arriving on the expiry cycle takes priority over the abort.
      ADDR: begin
        if (rx_valid) begin
          addr_d = AW'({addr_q, rx_byte});
          if (cnt_q == CntW'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = is_write_q ? DATA : READ_REQ;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (timer_expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end

      DATA: begin
        if (rx_valid) begin
          data_d = DW'({data_q, rx_byte});
          if (cnt_q == CntW'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (timer_expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end

      WRITE: begin
        mem_we   = 1'b1;
        txq_d[0] = ACK;
        idx_d    = '0;
        last_d   = '0;
        state_d  = SEND;
      end

      READ_REQ: begin
        mem_re  = 1'b1;
        state_d = READ_WAIT;
      end

      READ_WAIT: begin
        if (mem_rvalid) begin
          for (int i = 0; i < DATA_BYTES; i++) begin
            txq_d[i] = mem_rdata[8*(DATA_BYTES-1-i) +: 8];
          end
          idx_d   = '0;
          last_d  = IdxW'(DATA_BYTES - 1);
          state_d = SEND;
        end
      end

      // gap_q blocks a strobe in the cycle after each pulse.
      SEND: begin
        tx_byte = txq_q[idx_q];
        if (tx_ready && !gap_q) begin
          en_tx = 1'b1;
          gap_d = 1'b1;
          if (idx_q == last_q) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (rx_valid && ((state_q == WRITE) || (state_q == READ_REQ) ||
                     (state_q == READ_WAIT) || (state_q == SEND))) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      gap_q       <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < DATA_BYTES; i++) begin
        txq_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      frame_err_q <= frame_err_d;
      txq_q       <= txq_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected TX bytes and
// memory strobes into queues, a monitor pops and compares as the DUT emits them.
module tb_uart_cmd_parser;

  localparam int unsigned AB = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned TO = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic [7:0]     tx_byte;
  logic           en_tx;
  logic           tx_ready;
  logic [8*AB-1:0] mem_addr;
  logic [8*DB-1:0] mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic [8*DB-1:0] mem_rdata;
  logic           mem_rvalid;
  logic           frame_err;
  logic           busy;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .ADDR_BYTES    (AB),
    .DATA_BYTES    (DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_byte   (tx_byte),
    .en_tx     (en_tx),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_tx [$];
  logic [15:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [15:0] exp_ra [$];

  logic        hold_tx  = 1'b0;
  logic [31:0] rd_value = 32'h0;
  int          txb      = 0;
  logic        prev_en_tx = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected strobe with value %0h, expected none", name, act);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (en_tx) begin
        check("en_tx back-to-back", {63'b0, prev_en_tx}, 64'd0);
        if (exp_tx.size() == 0) unexpected("tx_byte", {56'b0, tx_byte});
        else check("tx_byte", {56'b0, tx_byte}, {56'b0, exp_tx.pop_front()});
      end
      prev_en_tx = en_tx;
      if (mem_we) begin
        if (exp_wa.size() == 0) unexpected("mem_we", {48'b0, mem_addr});
        else begin
          check("mem_we addr", {48'b0, mem_addr}, {48'b0, exp_wa.pop_front()});
          check("mem_we data", {32'b0, mem_wdata}, {32'b0, exp_wd.pop_front()});
        end
      end
      if (mem_re) begin
        if (exp_ra.size() == 0) unexpected("mem_re", {48'b0, mem_addr});
        else check("mem_re addr", {48'b0, mem_addr}, {48'b0, exp_ra.pop_front()});
      end
    end
  end

  // Transmitter model: busy for a few cycles after each en_tx, or held by hold_tx.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (en_tx) txb = 3;
      @(posedge clk);
      #1;
      if (txb > 0) txb--;
      tx_ready = (txb == 0) && !hold_tx;
    end
  end

  // Memory model: read data returns 5 cycles after mem_re.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_re) begin
        repeat (5) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = rd_value;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cyc = 0;
    @(negedge clk);
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: busy=1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send_write(input logic [15:0] a, input logic [31:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
    exp_tx.push_back(8'h06);
    send_byte(8'h57);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  initial begin
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    rst      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset en_tx", {63'b0, en_tx}, 64'd0);
    check("reset mem_we", {63'b0, mem_we}, 64'd0);
    check("reset mem_re", {63'b0, mem_re}, 64'd0);
    check("reset frame_err", {63'b0, frame_err}, 64'd0);
    check("reset tx_byte", {56'b0, tx_byte}, 64'd0);
    check("reset mem_addr", {48'b0, mem_addr}, 64'd0);
    check("reset mem_wdata", {32'b0, mem_wdata}, 64'd0);
    rst = 1'b1;

    // 1. Write
    send_write(16'h1234, 32'hDEADBEEF);
    wait_idle("write idle", 200);
    check("write frame_err", {63'b0, frame_err}, 64'd0);

    // 2. Read
    rd_value = 32'hCAFEF00D;
    exp_ra.push_back(16'h1234);
    exp_tx.push_back(8'hCA);
    exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hF0);
    exp_tx.push_back(8'h0D);
    send_byte(8'h52);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_idle("read idle", 300);
    check("read frame_err", {63'b0, frame_err}, 64'd0);
    check("read tx drained", 64'(exp_tx.size()), 64'd0);

    // 5. Overrun while SEND is stalled by tx_ready=0
    @(posedge clk);
    #1;
    hold_tx = 1'b1;
    send_write(16'h5566, 32'h11223344);
    repeat (4) @(posedge clk);
    #1;
    check("overrun busy before", {63'b0, busy}, 64'd1);
    check("overrun frame_err before", {63'b0, frame_err}, 64'd0);
    send_byte(8'h33);
    check("overrun frame_err", {63'b0, frame_err}, 64'd1);
    check("overrun still busy", {63'b0, busy}, 64'd1);
    hold_tx = 1'b0;
    wait_idle("overrun idle", 200);
    check("overrun tx drained", 64'(exp_tx.size()), 64'd0);

    // 3. Bad opcode, then a valid write
    do_reset();
    check("badop frame_err pre", {63'b0, frame_err}, 64'd0);
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_idle("badop idle", 200);
    check("badop frame_err", {63'b0, frame_err}, 64'd1);
    send_write(16'hABCD, 32'h01234567);
    wait_idle("badop write idle", 200);
    check("badop frame_err sticky", {63'b0, frame_err}, 64'd1);

    // 4. Timeout, then a fresh read
    do_reset();
    send_byte(8'h57);
    send_byte(8'h12);
    repeat (150) @(posedge clk);
    #1;
    check("timeout frame_err", {63'b0, frame_err}, 64'd1);
    check("timeout busy", {63'b0, busy}, 64'd0);
    rd_value = 32'h01020304;
    exp_ra.push_back(16'h0000);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h02);
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'h04);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_idle("timeout read idle", 300);

    // 6. Reset in the middle of the data field
    send_byte(8'h57);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2;
    check("midreset busy pre", {63'b0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    check("midreset busy", {63'b0, busy}, 64'd0);
    check("midreset frame_err", {63'b0, frame_err}, 64'd0);
    check("midreset mem_addr", {48'b0, mem_addr}, 64'd0);
    check("midreset mem_wdata", {32'b0, mem_wdata}, 64'd0);
    check("midreset en_tx", {63'b0, en_tx}, 64'd0);
    check("midreset tx_byte", {56'b0, tx_byte}, 64'd0);
    check("midreset mem_we", {63'b0, mem_we}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_write(16'h0102, 32'hA5A55A5A);
    wait_idle("postreset idle", 200);
    check("postreset frame_err", {63'b0, frame_err}, 64'd0);

    repeat (5) @(posedge clk);
    check("final tx queue", 64'(exp_tx.size()), 64'd0);
    check("final write queue", 64'(exp_wa.size()), 64'd0);
    check("final read queue", 64'(exp_ra.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
